layer_accumulator: RTL and testbench

Per-neuron multiply-accumulate stage sitting directly upstream of the activation block. It receives one input sample per beat together with one weight per neuron and accumulates the weighted sums for `size` neurons in parallel. It adds each neuron's bias, rescales and saturates the results to the Q-format data word, and presents them on a packed bus. The bus layout matches the activation block's `in_data`, so the two connect port-to-port.

---
 rtl/layer_pkg.sv | 31 +++
 rtl/mac_lane.sv | 41 ++++
 rtl/layer_accumulator.sv | 104 ++++++++++
 tb/tb_layer_accumulator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// rtl/layer_pkg.sv - shared types, limits and rescale helper (honours LAYER_ACC_SATURATE_EN)
package layer_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;

  localparam int DATA_SIZE_DEF = 16;
  localparam logic signed [DATA_SIZE_DEF-1:0] DATA_MAX = 16'sh7FFF;
  localparam logic signed [DATA_SIZE_DEF-1:0] DATA_MIN = 16'sh8000;

  // Arithmetic shift back to the data Q-format; the caller keeps the low dw bits,
  // so without the clamp the result wraps.
  function automatic logic signed [63:0] sat_rescale(input logic signed [63:0] acc,
                                                     input int dw, input int fb);
    logic signed [63:0] sh;
`ifdef LAYER_ACC_SATURATE_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
`endif
    sh = acc >>> fb;
`ifdef LAYER_ACC_SATURATE_EN
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sh > hi) sh = hi;
    else if (sh < lo) sh = lo;
`else
    if (dw < 0) sh = acc;
`endif
    return sh;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one signed multiply-accumulate lane with bias load and rescaled next-value output
module mac_lane
  import layer_pkg::*;
#(
  parameter int data_size = 16,
  parameter int frac_bits = 8,
  parameter int acc_w     = 41
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic signed [data_size-1:0] bias,
  input  logic                        en,
  input  logic signed [data_size-1:0] sample,
  input  logic signed [data_size-1:0] weight,
  output logic        [data_size-1:0] result
);

  logic signed [acc_w-1:0]       acc_q;
  logic signed [acc_w-1:0]       acc_d;
  logic signed [acc_w-1:0]       bias_ext;
  logic signed [2*data_size-1:0] prod;

  assign prod     = sample * weight;
  assign bias_ext = acc_w'(bias);

  always_comb begin
    acc_d = acc_q;
    if (clear)   acc_d = bias_ext <<< frac_bits;
    else if (en) acc_d = acc_q + acc_w'(prod);
  end

  // Rescale the next value so the top can register it on the edge that finishes.
  assign result = data_size'(sat_rescale(64'(acc_d), data_size, frac_bits));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/layer_accumulator.sv
// rtl/layer_accumulator.sv - per-neuron MAC stage: FSM, input counter, lane packing (LAYER_ACC_SATURATE_EN)
module layer_accumulator
  import layer_pkg::*;
#(
  parameter int data_size  = 16,
  parameter int size       = 3,
  parameter int frac_bits  = 8,
  parameter int max_inputs = 256,
  localparam int CNT_W     = $clog2(max_inputs + 1),
  localparam int ACC_W     = 2 * data_size + $clog2(max_inputs) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_inputs,
  input  logic [data_size*size-1:0] bias,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [data_size-1:0]      in_data,
  input  logic [data_size*size-1:0] weights,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [data_size*size-1:0] out_data,
  output logic                      busy
);

  acc_state_t               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     lane_clear;
  logic                     lane_en;
  logic                     capture;
  logic [data_size*size-1:0] lane_result;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_clear = 1'b0;
    lane_en    = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          lane_clear = 1'b1;
          cnt_d      = num_inputs;
          if (num_inputs == '0) begin
            state_d = DONE;
            capture = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          lane_en = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            capture = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      out_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) out_data <= lane_result;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  // Lane 0 sits in the MSBs of every packed bus.
  for (genvar i = 0; i < size; i++) begin : g_lane
    mac_lane #(
      .data_size(data_size),
      .frac_bits(frac_bits),
      .acc_w    (ACC_W)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (lane_clear),
      .bias   (bias[(size-i)*data_size-1 -: data_size]),
      .en     (lane_en),
      .sample (in_data),
      .weight (weights[(size-i)*data_size-1 -: data_size]),
      .result (lane_result[(size-i)*data_size-1 -: data_size])
    );
  end

endmodule

// File: tb/tb_layer_accumulator.sv
// tb/tb_layer_accumulator.sv - directed self-checking bench for layer_accumulator
module tb_layer_accumulator;
  import layer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [8:0]  num_inputs;
  logic [47:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [47:0] weights;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  layer_accumulator dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .num_inputs(num_inputs),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .weights   (weights),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pack3(input logic [15:0] l0, input logic [15:0] l1,
                                        input logic [15:0] l2);
    return {l0, l1, l2};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [47:0] held;
  logic [15:0] sat_pos;
  logic [15:0] sat_neg;

  initial begin
`ifdef LAYER_ACC_SATURATE_EN
    sat_pos = DATA_MAX;
    sat_neg = DATA_MIN;
`else
    sat_pos = 16'h0400;
    sat_neg = 16'hFC00;
`endif
    reset_n = 1'b0; start = 1'b0; num_inputs = '0; bias = '0;
    in_valid = 1'b0; in_data = '0; weights = '0; out_ready = 1'b0;
    #2;
    chk("reset_in_ready", 48'(in_ready), 48'd0);
    chk("reset_out_valid", 48'(out_valid), 48'd0);
    chk("reset_busy", 48'(busy), 48'd0);
    chk("reset_out_data", out_data, 48'd0);
    step();
    reset_n = 1'b1;
    step();

    // 1: nominal two-beat accumulation
    start = 1'b1; num_inputs = 9'd2; bias = '0;
    step();
    start = 1'b0;
    chk("t1_busy", 48'(busy), 48'd1);
    chk("t1_in_ready", 48'(in_ready), 48'd1);
    in_valid = 1'b1; in_data = 16'h0100; weights = pack3(16'h0100, 16'h0080, 16'h0000);
    step();
    chk("t1_no_early_valid", 48'(out_valid), 48'd0);
    in_data = 16'h0200;
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", 48'(out_valid), 48'd1);
    chk("t1_in_ready_low", 48'(in_ready), 48'd0);
    chk("t1_out_data", out_data, pack3(16'h0300, 16'h0180, 16'h0000));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_valid_drop", 48'(out_valid), 48'd0);
    chk("t1_idle", 48'(busy), 48'd0);

    // in_valid in IDLE must not start anything
    in_valid = 1'b1; in_data = 16'h7777; weights = pack3(16'h1111, 16'h1111, 16'h1111);
    step();
    in_valid = 1'b0;
    chk("idle_in_valid_ignored", 48'(busy), 48'd0);
    chk("idle_data_held", out_data, pack3(16'h0300, 16'h0180, 16'h0000));

    // 2: bias only, zero inputs
    start = 1'b1; num_inputs = 9'd0; bias = pack3(16'h0100, 16'h0050, 16'hFF00);
    step();
    start = 1'b0;
    chk("t2_out_valid", 48'(out_valid), 48'd1);
    chk("t2_in_ready", 48'(in_ready), 48'd0);
    chk("t2_out_data", out_data, pack3(16'h0100, 16'h0050, 16'hFF00));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 3: large positive then large negative sums
    start = 1'b1; num_inputs = 9'd4; bias = '0;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h7F00; weights = pack3(16'h7F00, 16'h7F00, 16'h7F00);
    repeat (4) step();
    in_valid = 1'b0;
    chk("t3_pos_valid", 48'(out_valid), 48'd1);
    chk("t3_pos_data", out_data, pack3(sat_pos, sat_pos, sat_pos));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    start = 1'b1; num_inputs = 9'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h8100;
    repeat (4) step();
    in_valid = 1'b0;
    chk("t3_neg_data", out_data, pack3(sat_neg, sat_neg, sat_neg));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 4: input stalls, output back-pressure, start ignored in DONE
    start = 1'b1; num_inputs = 9'd3; bias = pack3(16'h0010, 16'h0000, 16'h0000);
    step();
    start = 1'b0;
    weights = pack3(16'h0100, 16'h0200, 16'hFF00);
    in_valid = 1'b0; in_data = 16'h1234;
    step();
    in_valid = 1'b1; in_data = 16'h0100;
    step();
    in_valid = 1'b0; in_data = 16'h4000;
    step();
    chk("t4_stall_no_valid", 48'(out_valid), 48'd0);
    in_valid = 1'b1; in_data = 16'h0080;
    step();
    in_data = 16'hFF80;
    step();
    in_valid = 1'b0;
    held = pack3(16'h0110, 16'h0200, 16'hFF00);
    chk("t4_out_data", out_data, held);
    start = 1'b1; num_inputs = 9'd0; bias = pack3(16'h0AAA, 16'h0BBB, 16'h0CCC);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", 48'(out_valid), 48'd1);
      chk("t4_hold_data", out_data, held);
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_release_valid", 48'(out_valid), 48'd0);
    chk("t4_start_ignored", 48'(busy), 48'd0);
    chk("t4_data_after", out_data, held);

    // 5: reset in the middle of an accumulation
    start = 1'b1; num_inputs = 9'd3; bias = pack3(16'h0100, 16'h0100, 16'h0100);
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h0200; weights = pack3(16'h0100, 16'h0100, 16'h0100);
    step();
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_busy", 48'(busy), 48'd0);
    chk("t5_rst_in_ready", 48'(in_ready), 48'd0);
    chk("t5_rst_out_valid", 48'(out_valid), 48'd0);
    chk("t5_rst_out_data", out_data, 48'd0);
    step();
    reset_n = 1'b1;
    step();
    start = 1'b1; num_inputs = 9'd1; bias = pack3(16'h0100, 16'h0000, 16'h0000);
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h0100; weights = pack3(16'h0100, 16'h0100, 16'h0100);
    step();
    in_valid = 1'b0;
    chk("t5_fresh_valid", 48'(out_valid), 48'd1);
    chk("t5_fresh_data", out_data, pack3(16'h0200, 16'h0100, 16'h0100));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
